// File: rtl/sys_arr_pkg.sv
// Shared types for the systolic-array memory-side feed controller.
//   N_DEF / DW_DEF : default array dimension and element width
//   feed_state_t   : feed sequencer states
//   row_t          : one array row at the default geometry
package sys_arr_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    WAIT_SPACE,
    LOAD_I
  } feed_state_t;

  typedef logic [DW_DEF*N_DEF-1:0] row_t;

endpackage

// File: rtl/sa_out_fifo.sv
// First-word-fall-through FIFO buffering array output rows.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request; dropped when full unless a pop happens too
//   pop          : read request; ignored when empty
//   rdata        : head entry (zero while empty)
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
module sa_out_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push at full is still taken.
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sa_feed_ctrl.sv
// Memory-side feed controller for the systolic array.
// Sequences N weight rows then N input rows (optionally with partial sums)
// from a memory row stream onto the array bus, and buffers the array's
// unthrottled output rows in a credit-protected FIFO for a valid/ready port.
//   CLK, nRST                      : clock, asynchronous active-low reset
//   job_*                          : job offer / accept handshake
//   src_*                          : memory row stream (valid/ready)
//   weight_en..array_in_partials   : registered array input bus
//   fifo_has_space, drained        : array status
//   out_en, row_out, array_output  : array output rows (not stallable)
//   res_*                          : result row stream (valid/ready, FWFT)
//   busy, overflow                 : status; overflow is sticky until reset
// Optional: define SA_FEED_PERF_EN to add perf_jobs / perf_stall / perf_resbp.
module sa_feed_ctrl
  import sys_arr_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned OUT_DEPTH = 2*N
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  job_valid,
  input  logic                  job_has_ps,
  output logic                  job_ready,
  input  logic                  src_valid,
  input  logic [DW*N-1:0]       src_data,
  input  logic [DW*N-1:0]       src_ps,
  output logic                  src_ready,
  output logic                  weight_en,
  output logic                  input_en,
  output logic                  partial_en,
  output logic [$clog2(N)-1:0]  row_in_en,
  output logic [$clog2(N)-1:0]  row_ps_en,
  output logic [DW*N-1:0]       array_in,
  output logic [DW*N-1:0]       array_in_partials,
  input  logic                  fifo_has_space,
  input  logic                  drained,
  input  logic                  out_en,
  input  logic [$clog2(N)-1:0]  row_out,
  input  logic [DW*N-1:0]       array_output,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DW*N-1:0]       res_data,
  output logic [$clog2(N)-1:0]  res_row,
  output logic                  res_last,
  output logic                  busy,
  output logic                  overflow
`ifdef SA_FEED_PERF_EN
  ,
  output logic [31:0]           perf_jobs,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_resbp
`endif
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned CW = $clog2(OUT_DEPTH+1);
  localparam int unsigned SW = CW + 2;
  localparam int unsigned FW = DW*N + RW;

  feed_state_t      state_q, state_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic             has_ps_q, has_ps_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic             overflow_q, overflow_d;
  logic             weight_en_q, weight_en_d;
  logic             input_en_q, input_en_d;
  logic             partial_en_q, partial_en_d;
  logic [RW-1:0]    row_in_en_q, row_in_en_d;
  logic [RW-1:0]    row_ps_en_q, row_ps_en_d;
  logic [DW*N-1:0]  array_in_q, array_in_d;
  logic [DW*N-1:0]  array_in_partials_q, array_in_partials_d;

  logic             job_hs, beat, last_beat, space_ok, grant;
  logic [CW:0]      outst_sum;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]    fifo_rdata;

  // Credit check written as a sum so it cannot underflow when unexpected
  // out_en rows have pushed the FIFO past the credited amount.
  assign space_ok  = fifo_has_space &&
                     (SW'(fifo_count) + SW'(outst_q) + SW'(N) <= SW'(OUT_DEPTH));
  assign job_hs    = job_valid && job_ready;
  assign beat      = src_valid && src_ready;
  assign last_beat = beat && (cnt_q == RW'(N-1));
  assign grant     = (state_q == WAIT_SPACE) && space_ok;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (job_valid) state_d = LOAD_W;
      LOAD_W:     if (last_beat) state_d = WAIT_SPACE;
      WAIT_SPACE: if (space_ok)  state_d = LOAD_I;
      LOAD_I:     if (last_beat) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    job_ready = (state_q == IDLE);
    src_ready = (state_q == LOAD_W) || (state_q == LOAD_I);
  end

  // Datapath, credits and array bus next values
  always_comb begin
    cnt_d               = cnt_q;
    has_ps_d            = has_ps_q;
    weight_en_d         = 1'b0;
    input_en_d          = 1'b0;
    partial_en_d        = 1'b0;
    row_in_en_d         = '0;
    row_ps_en_d         = '0;
    array_in_d          = '0;
    array_in_partials_d = '0;
    if (job_hs) begin
      cnt_d    = '0;
      has_ps_d = job_has_ps;
    end
    if (beat) begin
      cnt_d       = cnt_q + RW'(1);
      row_in_en_d = cnt_q;
      array_in_d  = src_data;
      if (state_q == LOAD_W) begin
        weight_en_d = 1'b1;
      end else begin
        input_en_d = 1'b1;
        if (has_ps_q) begin
          partial_en_d        = 1'b1;
          row_ps_en_d         = cnt_q;
          array_in_partials_d = src_ps;
        end
      end
    end
    outst_sum = {1'b0, outst_q} + (grant ? (CW+1)'(N) : '0);
    if (out_en && (outst_sum != '0)) outst_sum = outst_sum - (CW+1)'(1);
    outst_d    = outst_sum[CW-1:0];
    overflow_d = overflow_q || (out_en && fifo_full && !fifo_pop);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q               <= '0;
      has_ps_q            <= 1'b0;
      outst_q             <= '0;
      overflow_q          <= 1'b0;
      weight_en_q         <= 1'b0;
      input_en_q          <= 1'b0;
      partial_en_q        <= 1'b0;
      row_in_en_q         <= '0;
      row_ps_en_q         <= '0;
      array_in_q          <= '0;
      array_in_partials_q <= '0;
    end else begin
      cnt_q               <= cnt_d;
      has_ps_q            <= has_ps_d;
      outst_q             <= outst_d;
      overflow_q          <= overflow_d;
      weight_en_q         <= weight_en_d;
      input_en_q          <= input_en_d;
      partial_en_q        <= partial_en_d;
      row_in_en_q         <= row_in_en_d;
      row_ps_en_q         <= row_ps_en_d;
      array_in_q          <= array_in_d;
      array_in_partials_q <= array_in_partials_d;
    end
  end

  sa_out_fifo #(
    .W     (FW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (out_en),
    .wdata ({row_out, array_output}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_pop          = res_valid && res_ready;
  assign res_valid         = !fifo_empty;
  assign res_data          = fifo_rdata[DW*N-1:0];
  assign res_row           = fifo_rdata[FW-1:DW*N];
  assign res_last          = (res_row == RW'(N-1));
  // busy only clears once the array also reports itself drained.
  assign busy              = (state_q != IDLE) || !fifo_empty || (outst_q != '0) || !drained;
  assign overflow          = overflow_q;
  assign weight_en         = weight_en_q;
  assign input_en          = input_en_q;
  assign partial_en        = partial_en_q;
  assign row_in_en         = row_in_en_q;
  assign row_ps_en         = row_ps_en_q;
  assign array_in          = array_in_q;
  assign array_in_partials = array_in_partials_q;

`ifdef SA_FEED_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_resbp_q, perf_resbp_d;

  always_comb begin
    perf_jobs_d  = perf_jobs_q;
    perf_stall_d = perf_stall_q;
    perf_resbp_d = perf_resbp_q;
    if (job_hs && (perf_jobs_q != '1))                      perf_jobs_d  = perf_jobs_q + 32'd1;
    if ((state_q == WAIT_SPACE) && (perf_stall_q != '1))    perf_stall_d = perf_stall_q + 32'd1;
    if (res_valid && !res_ready && (perf_resbp_q != '1))    perf_resbp_d = perf_resbp_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
      perf_resbp_q <= '0;
    end else begin
      perf_jobs_q  <= perf_jobs_d;
      perf_stall_q <= perf_stall_d;
      perf_resbp_q <= perf_resbp_d;
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
  assign perf_resbp = perf_resbp_q;
`endif

endmodule
